parking_lot_sensor_emulator: RTL

Drives the two parking-gate photo-sensor lines (`sensor_a_o` toward the street, `sensor_b_o` toward the lot) through the exact four-phase patterns a car produces when entering, exiting, or backing out. It is the stimulus end of the sensor interface: its `sensor_a_o`/`sensor_b_o` wire directly to the occupancy counter's `sensor_a_i`/`sensor_b_i` in system benches and on-board self-test. Commands are accepted through a valid/ready handshake. Completed enter and exit events are tallied, so the display count can be checked against a known reference.

---
 rtl/parking_lot_sensor_emulator.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/parking_lot_sensor_emulator.sv
// Parking-gate sensor emulator: replays the four-phase photo-sensor
// patterns a car produces when entering, exiting or backing out of the lot,
// and tallies completed enter and exit events.
module parking_lot_sensor_emulator #(
    parameter int DWELL_CYCLES = 4,
    parameter int COUNT_W      = 8
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               start_i,
    input  logic [1:0]         cmd_i,
    output logic               ready_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               sensor_a_o,
    output logic               sensor_b_o,
    output logic [COUNT_W-1:0] enter_count_o,
    output logic [COUNT_W-1:0] exit_count_o
);

    localparam int            DW         = $clog2(DWELL_CYCLES + 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);

    localparam logic [1:0] CMD_ENTER   = 2'b00;
    localparam logic [1:0] CMD_EXIT    = 2'b01;
    localparam logic [1:0] CMD_BACKOUT = 2'b10;
    localparam logic [1:0] CMD_RSVD    = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        P1,
        P2,
        P3,
        GAP
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         cmd_q, cmd_d;
    logic [DW-1:0]      dwellCnt_q, dwellCnt_d;
    logic               sensorA_q, sensorA_d;
    logic               sensorB_q, sensorB_d;
    logic               done_q;
    logic               finish;
    logic               phaseEnd;
    logic               accept;
    logic [COUNT_W-1:0] enterCnt_q, exitCnt_q;

    // Sequencer: walks IDLE -> P1 -> P2 -> P3 -> GAP -> IDLE, holding each
    // phase for DWELL_CYCLES cycles, and computes the sensor levels that the
    // next state must present so the outputs can be registered glitch-free.
    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        dwellCnt_d = dwellCnt_q + DW'(1);
        finish     = 1'b0;
        phaseEnd   = (dwellCnt_q == DWELL_LAST);
        accept     = start_i && (state_q == IDLE) && (cmd_i != CMD_RSVD);
        sensorA_d  = 1'b0;
        sensorB_d  = 1'b0;

        case (state_q)
            IDLE: begin
                dwellCnt_d = '0;
                if (accept) begin
                    state_d = P1;
                    cmd_d   = cmd_i;
                end
            end
            P1: begin
                if (phaseEnd) begin
                    state_d    = P2;
                    dwellCnt_d = '0;
                end
            end
            P2: begin
                if (phaseEnd) begin
                    state_d    = P3;
                    dwellCnt_d = '0;
                end
            end
            P3: begin
                if (phaseEnd) begin
                    state_d    = GAP;
                    dwellCnt_d = '0;
                end
            end
            GAP: begin
                if (phaseEnd) begin
                    state_d    = IDLE;
                    dwellCnt_d = '0;
                    finish     = 1'b1;
                end
            end
            default: begin
                state_d    = IDLE;
                dwellCnt_d = '0;
            end
        endcase

        case (state_d)
            P1: begin
                sensorA_d = (cmd_d != CMD_EXIT);
                sensorB_d = (cmd_d == CMD_EXIT);
            end
            P2: begin
                sensorA_d = 1'b1;
                sensorB_d = 1'b1;
            end
            P3: begin
                sensorA_d = (cmd_d == CMD_EXIT) || (cmd_d == CMD_BACKOUT);
                sensorB_d = (cmd_d == CMD_ENTER);
            end
            default: begin
                sensorA_d = 1'b0;
                sensorB_d = 1'b0;
            end
        endcase
    end

    // State, latched command, dwell timer and registered sensor lines.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            cmd_q      <= CMD_ENTER;
            dwellCnt_q <= '0;
            sensorA_q  <= 1'b0;
            sensorB_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            dwellCnt_q <= dwellCnt_d;
            sensorA_q  <= sensorA_d;
            sensorB_q  <= sensorB_d;
        end
    end

    // Completion pulse and event tallies, updated as GAP is left; back-out
    // deliberately touches neither tally and both wrap silently.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            done_q     <= 1'b0;
            enterCnt_q <= '0;
            exitCnt_q  <= '0;
        end else begin
            done_q <= finish;
            if (finish && (cmd_q == CMD_ENTER)) begin
                enterCnt_q <= enterCnt_q + COUNT_W'(1);
            end
            if (finish && (cmd_q == CMD_EXIT)) begin
                exitCnt_q <= exitCnt_q + COUNT_W'(1);
            end
        end
    end

    assign ready_o       = (state_q == IDLE);
    assign busy_o        = ~ready_o;
    assign done_o        = done_q;
    assign sensor_a_o    = sensorA_q;
    assign sensor_b_o    = sensorB_q;
    assign enter_count_o = enterCnt_q;
    assign exit_count_o  = exitCnt_q;

endmodule
